// File: rtl/gt_pattern_player_pkg.sv
// gt_pattern_pkg: shared types and constants for the gt_pattern_player playback engine.
`default_nettype none

package gt_pattern_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_PLAY  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int LOOP_CNT_W = 32;

   // PRBS-31, x^31 + x^28 + 1: feedback taps are bits 30 and 27 of the shift register.
   localparam int          PRBS31_TAP_HI = 30;
   localparam int          PRBS31_TAP_LO = 27;
   localparam logic [30:0] PRBS31_SEED   = 31'h7FFF_FFFF;

   function automatic logic prbs31_fb(input logic [30:0] s);
      return s[PRBS31_TAP_HI] ^ s[PRBS31_TAP_LO];
   endfunction

endpackage

`default_nettype wire

// File: rtl/gt_pattern_player_if.sv
// gt_pattern_player_if: RAM write port, playback control and per-channel TX data bundle.
`default_nettype none

interface gt_pattern_player_if
   import gt_pattern_pkg::*;
#(
   parameter int CHN_NUM = 6,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 1024
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int IDX_W  = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1;

   logic                      ram_we;
   logic [IDX_W-1:0]          ram_idx;
   logic [ADDR_W-1:0]         ram_addr;
   logic [DATA_W-1:0]         ram_data;
   logic [ADDR_W-1:0]         cfg_last;
   logic                      cfg_loop;
   logic                      reg_start;
   logic                      reg_reset;
   logic [CHN_NUM*DATA_W-1:0] gt_data;
   logic                      busy;
   logic                      done;
   logic [LOOP_CNT_W-1:0]     loop_cnt;
   logic                      wr_drop;

   modport master (
      output ram_we, ram_idx, ram_addr, ram_data, cfg_last, cfg_loop, reg_start, reg_reset,
      input  gt_data, busy, done, loop_cnt, wr_drop
   );

   modport slave (
      input  ram_we, ram_idx, ram_addr, ram_data, cfg_last, cfg_loop, reg_start, reg_reset,
      output gt_data, busy, done, loop_cnt, wr_drop
   );

endinterface

`default_nettype wire

// File: rtl/gt_pattern_ram.sv
// gt_pattern_ram: simple dual-port pattern RAM, one write port, registered read (1-cycle latency).
`default_nettype none

module gt_pattern_ram #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 1024,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  wire logic              clk_i,
   input  wire logic              we_i,
   input  wire logic [ADDR_W-1:0] waddr_i,
   input  wire logic [DATA_W-1:0] wdata_i,
   input  wire logic              re_i,
   input  wire logic [ADDR_W-1:0] raddr_i,
   output      logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/gt_pattern_player.sv
// gt_pattern_player: lockstep multi-channel pattern playback onto the GT TX data path.
// Build option GT_IDLE_PRBS_EN: drive PRBS-31 instead of zeros while IDLE/DONE.
`default_nettype none

module gt_pattern_player
   import gt_pattern_pkg::*;
#(
   parameter int CHN_NUM = 6,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 1024
) (
   input wire logic      gt_clk_i,
   input wire logic      gt_rstb_i,
   gt_pattern_player_if.slave bus
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int BUS_W  = CHN_NUM * DATA_W;

   state_e                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [ADDR_W-1:0]     last_q, last_d;
   logic                  loop_q, loop_d;
   logic [LOOP_CNT_W-1:0] loop_cnt_q, loop_cnt_d;
   logic                  wr_drop_q, wr_drop_d;
   logic                  start_q;
   logic                  vld_q;
   logic [BUS_W-1:0]      gt_data_q, gt_data_d;
   logic [BUS_W-1:0]      ram_rd;
   logic [BUS_W-1:0]      idle_data;
   logic                  busy;
   logic                  start_rise;
   logic                  rd_en;
   logic                  idx_ok;

   assign busy       = (state_q == ST_PRIME) || (state_q == ST_PLAY);
   assign start_rise = bus.reg_start & ~start_q;
   assign rd_en      = (state_q == ST_PLAY);
   assign idx_ok     = int'(bus.ram_idx) < CHN_NUM;

   for (genvar c = 0; c < CHN_NUM; c++) begin : g_chan
      logic we_c;
      assign we_c = bus.ram_we & ~busy & (int'(bus.ram_idx) == c);

      gt_pattern_ram #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_ram (
         .clk_i   (gt_clk_i),
         .we_i    (we_c),
         .waddr_i (bus.ram_addr),
         .wdata_i (bus.ram_data),
         .re_i    (rd_en),
         .raddr_i (addr_q),
         .rdata_o (ram_rd[c*DATA_W +: DATA_W])
      );
   end

`ifdef GT_IDLE_PRBS_EN
   for (genvar c = 0; c < CHN_NUM; c++) begin : g_prbs
      logic [30:0]       lfsr_q, lfsr_d;
      logic [DATA_W-1:0] bits;

      // Oldest generated bit lands in the MSB of the output word.
      always_comb begin
         lfsr_d = lfsr_q;
         bits   = '0;
         for (int i = 0; i < DATA_W; i++) begin
            bits[DATA_W-1-i] = prbs31_fb(lfsr_d);
            lfsr_d           = {lfsr_d[29:0], bits[DATA_W-1-i]};
         end
      end

      always_ff @(posedge gt_clk_i or negedge gt_rstb_i) begin
         if (!gt_rstb_i) begin
            lfsr_q <= PRBS31_SEED ^ 31'(c);
         end else if (bus.reg_reset) begin
            lfsr_q <= PRBS31_SEED ^ 31'(c);
         end else begin
            lfsr_q <= lfsr_d;
         end
      end

      assign idle_data[c*DATA_W +: DATA_W] = bits;
   end
`else
   assign idle_data = '0;
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      last_d     = last_q;
      loop_d     = loop_q;
      loop_cnt_d = loop_cnt_q;
      wr_drop_d  = wr_drop_q | (bus.ram_we & busy & idx_ok);
      // vld_q travels with the RAM read data, so the idle value only replaces
      // samples that were never read, never the tail of a pass.
      gt_data_d  = vld_q ? ram_rd : idle_data;

      case (state_q)
         ST_IDLE: begin
            if (start_rise) begin
               state_d = ST_PRIME;
               addr_d  = '0;
               last_d  = bus.cfg_last;
               loop_d  = bus.cfg_loop;
            end
         end
         ST_PRIME: begin
            state_d = ST_PLAY;
            addr_d  = '0;
         end
         ST_PLAY: begin
            if (addr_q == last_q) begin
               loop_cnt_d = (loop_cnt_q == '1) ? loop_cnt_q : loop_cnt_q + 1'b1;
               addr_d     = '0;
               if (!loop_q) begin
                  state_d = ST_DONE;
               end
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (!bus.reg_start) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge gt_clk_i or negedge gt_rstb_i) begin
      if (!gt_rstb_i) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         last_q     <= '0;
         loop_q     <= 1'b0;
         loop_cnt_q <= '0;
         wr_drop_q  <= 1'b0;
         start_q    <= 1'b0;
         vld_q      <= 1'b0;
         gt_data_q  <= '0;
      end else if (bus.reg_reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         last_q     <= '0;
         loop_q     <= 1'b0;
         loop_cnt_q <= '0;
         wr_drop_q  <= 1'b0;
         start_q    <= 1'b0;
         vld_q      <= 1'b0;
         gt_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         last_q     <= last_d;
         loop_q     <= loop_d;
         loop_cnt_q <= loop_cnt_d;
         wr_drop_q  <= wr_drop_d;
         start_q    <= bus.reg_start;
         vld_q      <= rd_en;
         gt_data_q  <= gt_data_d;
      end
   end

   assign bus.gt_data  = gt_data_q;
   assign bus.busy     = busy;
   assign bus.done     = (state_q == ST_DONE);
   assign bus.loop_cnt = loop_cnt_q;
   assign bus.wr_drop  = wr_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_gt_pattern_player.sv
// tb_gt_pattern_player: scoreboard bench; expected TX words come from a memory model of the pattern RAMs.
`default_nettype none

module tb_gt_pattern_player;

   localparam int CHN = 6;
   localparam int DW  = 32;
   localparam int DEP = 1024;
   localparam int BW  = CHN * DW;

   logic clk  = 1'b0;
   logic rstb = 1'b0;
   always #5 clk = ~clk;

   gt_pattern_player_if #(.CHN_NUM(CHN), .DATA_W(DW), .DEPTH(DEP)) bus ();

   gt_pattern_player #(.CHN_NUM(CHN), .DATA_W(DW), .DEPTH(DEP)) dut (
      .gt_clk_i  (clk),
      .gt_rstb_i (rstb),
      .bus       (bus)
   );

   typedef struct {
      int unsigned   cyc;
      logic [BW-1:0] val;
   } exp_t;

   exp_t        exp_q[$];
   logic [DW-1:0] mem [CHN][DEP];
   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   logic [31:0] exp_cnt  = '0;
   logic        exp_drop = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: pop the expected word scheduled for this cycle and compare.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         chk("gt_data", bus.gt_data, e.val);
      end
   end

   function automatic logic [BW-1:0] vec(input int a);
      logic [BW-1:0] v;
      for (int c = 0; c < CHN; c++) v[c*DW +: DW] = mem[c][a];
      return v;
   endfunction

   function automatic void push(input int unsigned t, input logic [BW-1:0] v);
      exp_t e;
      e.cyc = t;
      e.val = v;
      exp_q.push_back(e);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int unsigned t);
      while (cyc < t) tick();
   endtask

   task automatic wr(input int idx, input int addr, input logic [DW-1:0] data);
      bus.ram_we   = 1'b1;
      bus.ram_idx  = 3'(idx);
      bus.ram_addr = 10'(addr);
      bus.ram_data = data;
      tick();
      bus.ram_we   = 1'b0;
      if (idx < CHN) mem[idx][addr] = data;
   endtask

   task automatic pulse_start(input int last, input logic loop);
      bus.cfg_last  = 10'(last);
      bus.cfg_loop  = loop;
      bus.reg_start = 1'b1;
      tick();
      bus.reg_start = 1'b0;
      bus.cfg_last  = 10'($urandom_range(0, 1023));
      bus.cfg_loop  = ~loop;
   endtask

   task automatic soft_reset();
      bus.reg_reset = 1'b1;
      tick();
      bus.reg_reset = 1'b0;
      exp_cnt  = '0;
      exp_drop = 1'b0;
      tick();
      chk("soft_reset loop_cnt", BW'(bus.loop_cnt), BW'(exp_cnt));
   endtask

   // One pass of last+1 samples, first sample 3 cycles after the start edge.
   task automatic run_oneshot(input int last, input bit drop);
      int unsigned n = cyc;
      for (int j = 0; j <= last; j++) push(n + 4 + j, vec(j));
      for (int j = 1; j <= 3; j++) push(n + 4 + last + j, '0);
      pulse_start(last, 1'b0);
      wait_cyc(n + 2);
      chk("busy in play", BW'(bus.busy), BW'(1));
      if (drop) begin
         wait_cyc(n + 3);
         bus.ram_we   = 1'b1;
         bus.ram_idx  = 3'd1;
         bus.ram_addr = 10'd2;
         bus.ram_data = 32'hDEAD_BEEF;
         tick();
         bus.ram_we   = 1'b0;
         exp_drop     = 1'b1;
      end
      wait_cyc(n + last + 3);
      exp_cnt = exp_cnt + 1;
      chk("done", BW'(bus.done), BW'(1));
      chk("busy in done", BW'(bus.busy), BW'(0));
      chk("loop_cnt oneshot", BW'(bus.loop_cnt), BW'(exp_cnt));
      chk("wr_drop", BW'(bus.wr_drop), BW'(exp_drop));
      wait_cyc(n + last + 4);
      chk("done cleared", BW'(bus.done), BW'(0));
      wait_cyc(n + last + 8);
   endtask

   // Loop for nplay PLAY cycles, then soft reset.
   task automatic run_loop(input int last, input int nplay);
      int unsigned n = cyc;
      for (int j = 0; j <= nplay - 2; j++) push(n + 4 + j, vec(j % (last + 1)));
      for (int j = 0; j < 3; j++) push(n + 3 + nplay + j, '0);
      pulse_start(last, 1'b1);
      wait_cyc(n + 2);
      chk("busy loop", BW'(bus.busy), BW'(1));
      wait_cyc(n + 2 + nplay);
      exp_cnt = exp_cnt + 32'(nplay / (last + 1));
      chk("loop_cnt loop", BW'(bus.loop_cnt), BW'(exp_cnt));
      chk("busy still looping", BW'(bus.busy), BW'(1));
      bus.reg_reset = 1'b1;
      tick();
      exp_cnt  = '0;
      exp_drop = 1'b0;
      chk("busy after reg_reset", BW'(bus.busy), BW'(0));
      chk("loop_cnt after reg_reset", BW'(bus.loop_cnt), BW'(0));
      chk("wr_drop after reg_reset", BW'(bus.wr_drop), BW'(0));
      bus.reg_reset = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int unsigned n;
      int          last;
      bus.ram_we    = 1'b0;
      bus.ram_idx   = '0;
      bus.ram_addr  = '0;
      bus.ram_data  = '0;
      bus.cfg_last  = '0;
      bus.cfg_loop  = 1'b0;
      bus.reg_start = 1'b0;
      bus.reg_reset = 1'b0;
      repeat (3) tick();
      chk("reset gt_data", bus.gt_data, '0);
      chk("reset busy", BW'(bus.busy), BW'(0));
      chk("reset done", BW'(bus.done), BW'(0));
      chk("reset loop_cnt", BW'(bus.loop_cnt), BW'(0));
      chk("reset wr_drop", BW'(bus.wr_drop), BW'(0));
      rstb = 1'b1;
      tick();

      for (int c = 0; c < CHN; c++)
         for (int a = 0; a < 8; a++)
            wr(c, a, {8'(c), 8'h00, 16'(a)});

      run_oneshot(7, 1'b0);
      soft_reset();
      run_loop(7, 40);

      run_oneshot(7, 1'b1);
      run_oneshot(7, 1'b0);
      wr(6, 3, 32'h1234_5678);
      tick();
      chk("wr_drop after idx6", BW'(bus.wr_drop), BW'(1));
      soft_reset();

      for (int c = 0; c < CHN; c++) wr(c, 0, 32'hA5A5_A5A5);
      run_loop(0, 10);

      // Asynchronous reset mid-PLAY, asserted between clock edges.
      n = cyc;
      for (int j = 0; j <= 6; j++) push(n + 4 + j, vec(j % 8));
      pulse_start(7, 1'b1);
      wait_cyc(n + 10);
      #6;
      rstb = 1'b0;
      #1;
      chk("async gt_data", bus.gt_data, '0);
      chk("async busy", BW'(bus.busy), BW'(0));
      chk("async loop_cnt", BW'(bus.loop_cnt), BW'(0));
      chk("async wr_drop", BW'(bus.wr_drop), BW'(0));
      exp_cnt  = '0;
      exp_drop = 1'b0;
      tick();
      tick();
      rstb = 1'b1;
      tick();
      run_oneshot(7, 1'b0);

      for (int r = 0; r < 4; r++) begin
         last = int'($urandom_range(0, 15));
         for (int c = 0; c < CHN; c++)
            for (int a = 0; a <= last; a++)
               wr(c, a, $urandom);
         if ($urandom_range(0, 1) == 1) run_oneshot(last, 1'b0);
         else run_loop(last, int'($urandom_range(last + 2, 3 * last + 8)));
      end

      repeat (5) tick();
      chk("scoreboard drained", BW'(exp_q.size()), BW'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
